// File: rtl/fsm_pw_lockout.sv
// rtl/fsm_pw_lockout.sv - PW_LEN-digit password checker with timeout, fail counter and timed lockout
//
// Purpose:
//   Checks a PW_LEN-digit code entered one digit per rising edge of enable_data.
//   The whole sequence is always collected before the verdict (no early reject).
//   An inactivity timeout fails a stalled entry; MAX_FAILS consecutive failures
//   lock the block for LOCK_CYCLES clocks.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_a        in   asynchronous reset, active-low
//   enable_data  in   asynchronous digit-valid level; each rising edge enters one digit
//   entrada_pw   in   digit value, quasi-static around the enable_data edge
//   pass         out  high while the code is accepted
//   fail_pulse   out  one-cycle pulse per failed attempt
//   locked       out  high while locked out
//   estado_led   out  state code: IDLE=0 ENTRY=1 PASS=2 FAIL=3 LOCKED=4
//   fail_count   out  consecutive failures so far, saturating at MAX_FAILS
//   strobe_dbg   out  internal single-cycle digit strobe

module fsm_pw_lockout #(
    parameter int                        DIGIT_W        = 4,
    parameter int                        PW_LEN         = 4,
    parameter logic [PW_LEN*DIGIT_W-1:0] PW_CODE        = 16'h6987,
    parameter int                        MAX_FAILS      = 3,
    parameter int                        LOCK_CYCLES    = 1000,
    parameter int                        TIMEOUT_CYCLES = 5000
) (
    input  logic                           clk,
    input  logic                           rst_a,
    input  logic                           enable_data,
    input  logic [DIGIT_W-1:0]             entrada_pw,
    output logic                           pass,
    output logic                           fail_pulse,
    output logic                           locked,
    output logic [2:0]                     estado_led,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
    output logic                           strobe_dbg
);

    localparam int IDX_W = $clog2(PW_LEN);
    localparam int FC_W  = $clog2(MAX_FAILS + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LC_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        PASS   = 3'd2,
        FAIL   = 3'd3,
        LOCKED = 3'd4
    } state_t;

    state_t             state, state_d;
    logic               s1, s2, s3;
    logic               strobe;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               mismatch, mismatch_d;
    logic [TO_W-1:0]    to_cnt, to_cnt_d;
    logic [LC_W-1:0]    lock_cnt, lock_cnt_d;
    logic [FC_W-1:0]    fail_count_d;
    logic [FC_W-1:0]    fc_inc;
    logic               digit_bad;

    // Expected digits, digit 0 being the most significant (first entered).
    logic [DIGIT_W-1:0] code_digit [PW_LEN];

    for (genvar g = 0; g < PW_LEN; g++) begin : g_digits
        assign code_digit[g] = PW_CODE[(PW_LEN-1-g)*DIGIT_W +: DIGIT_W];
    end

    // s1/s2 resynchronise the button; s3 is the delayed copy for edge detection.
    assign strobe    = s2 & ~s3;
    assign digit_bad = (entrada_pw != code_digit[idx]);
    assign fc_inc    = (fail_count == FC_W'(MAX_FAILS)) ? fail_count : fail_count + 1'b1;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            idx        <= '0;
            mismatch   <= 1'b0;
            to_cnt     <= '0;
            lock_cnt   <= '0;
            fail_count <= '0;
        end else begin
            state      <= state_d;
            s1         <= enable_data;
            s2         <= s1;
            s3         <= s2;
            idx        <= idx_d;
            mismatch   <= mismatch_d;
            to_cnt     <= to_cnt_d;
            lock_cnt   <= lock_cnt_d;
            fail_count <= fail_count_d;
        end
    end

    always_comb begin
        state_d      = state;
        idx_d        = '0;
        mismatch_d   = 1'b0;
        to_cnt_d     = '0;
        lock_cnt_d   = '0;
        fail_count_d = fail_count;

        case (state)
            IDLE: begin
                if (strobe) begin
                    mismatch_d = (entrada_pw != code_digit[0]);
                    idx_d      = IDX_W'(1);
                    state_d    = ENTRY;
                end
            end

            ENTRY: begin
                // A strobe takes priority over a timeout expiring in the same cycle.
                if (strobe) begin
                    if (idx == IDX_W'(PW_LEN - 1)) begin
                        if (mismatch | digit_bad) begin
                            state_d = FAIL;
                        end else begin
                            state_d      = PASS;
                            fail_count_d = '0;
                        end
                    end else begin
                        idx_d      = idx + 1'b1;
                        mismatch_d = mismatch | digit_bad;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = FAIL;
                end else begin
                    idx_d      = idx;
                    mismatch_d = mismatch;
                    to_cnt_d   = to_cnt + 1'b1;
                end
            end

            PASS: begin
                if (strobe && (entrada_pw != '0)) begin
                    state_d = IDLE;
                end
            end

            FAIL: begin
                fail_count_d = fc_inc;
                state_d      = (fc_inc == FC_W'(MAX_FAILS)) ? LOCKED : IDLE;
            end

            LOCKED: begin
                // Strobes are deliberately ignored here.
                if (lock_cnt == LC_W'(LOCK_CYCLES - 1)) begin
                    state_d      = IDLE;
                    fail_count_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pass       = (state == PASS);
    assign fail_pulse = (state == FAIL);
    assign locked     = (state == LOCKED);
    assign estado_led = state;
    assign strobe_dbg = strobe;

endmodule

// File: tb/tb_fsm_pw_lockout.sv
// tb/tb_fsm_pw_lockout.sv - self-checking bench for fsm_pw_lockout

module tb_fsm_pw_lockout;

    logic       clk         = 1'b0;
    logic       rst_a       = 1'b0;
    logic       enable_data = 1'b0;
    logic [3:0] entrada_pw  = 4'd0;
    logic       pass;
    logic       fail_pulse;
    logic       locked;
    logic [2:0] estado_led;
    logic [1:0] fail_count;
    logic       strobe_dbg;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fsm_pw_lockout #(
        .DIGIT_W        (4),
        .PW_LEN         (4),
        .PW_CODE        (16'h6987),
        .MAX_FAILS      (3),
        .LOCK_CYCLES    (20),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .enable_data (enable_data),
        .entrada_pw  (entrada_pw),
        .pass        (pass),
        .fail_pulse  (fail_pulse),
        .locked      (locked),
        .estado_led  (estado_led),
        .fail_count  (fail_count),
        .strobe_dbg  (strobe_dbg)
    );

    typedef struct {
        logic [3:0] digit;
        bit         chk_fc;
        int         exp_pass;
        int         exp_fpulse;
        int         exp_locked;
        int         exp_estado;
        int         exp_fc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        enable_data = 1'b0;
        entrada_pw  = 4'd0;
        rst_a       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
    endtask

    // Returns 1 time unit after the edge that consumes the digit's strobe.
    task automatic send_digit(input logic [3:0] d);
        @(posedge clk);
        #1;
        entrada_pw = d;
        repeat (3) @(posedge clk);
        #1;
        enable_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enable_data = 1'b0;
    endtask

    task automatic send_code(input logic [15:0] code);
        for (int k = 0; k < 4; k++) send_digit(code[15-4*k -: 4]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   fail_at, pulses, lock_cyc, cnt, p1, p2;
        bit   saw_entry, saw_fail;
        logic [3:0] lk [4];

        vecs[0] = '{4'd6, 1'b1, 0, 0, 0, 1, 0};
        vecs[1] = '{4'd9, 1'b1, 0, 0, 0, 1, 0};
        vecs[2] = '{4'd8, 1'b1, 0, 0, 0, 1, 0};
        vecs[3] = '{4'd7, 1'b1, 1, 0, 0, 2, 0};
        vecs[4] = '{4'd0, 1'b1, 1, 0, 0, 2, 0};
        vecs[5] = '{4'd5, 1'b1, 0, 0, 0, 0, 0};
        vecs[6] = '{4'd6, 1'b1, 0, 0, 0, 1, 0};
        vecs[7] = '{4'd9, 1'b1, 0, 0, 0, 1, 0};
        vecs[8] = '{4'd1, 1'b1, 0, 0, 0, 1, 0};
        vecs[9] = '{4'd7, 1'b0, 0, 1, 0, 3, 0};

        // Reset state
        #12;
        chk("rst_pass",   pass,       0);
        chk("rst_fail",   fail_pulse, 0);
        chk("rst_locked", locked,     0);
        chk("rst_estado", estado_led, 0);
        chk("rst_fc",     fail_count, 0);
        chk("rst_strobe", strobe_dbg, 0);
        do_reset();

        // Tests 1 and 2: pass, hold with 0, leave with 5, then a wrong code
        for (int i = 0; i < 10; i++) begin
            send_digit(vecs[i].digit);
            chk($sformatf("vec%0d_pass", i),   pass,       vecs[i].exp_pass);
            chk($sformatf("vec%0d_fpulse", i), fail_pulse, vecs[i].exp_fpulse);
            chk($sformatf("vec%0d_locked", i), locked,     vecs[i].exp_locked);
            chk($sformatf("vec%0d_estado", i), estado_led, vecs[i].exp_estado);
            if (vecs[i].chk_fc) chk($sformatf("vec%0d_fc", i), fail_count, vecs[i].exp_fc);
        end
        @(posedge clk);
        #1;
        chk("t2_after_estado", estado_led, 0);
        chk("t2_after_fpulse", fail_pulse, 0);
        chk("t2_after_fc",     fail_count, 1);

        // Test 3: three wrong codes -> lockout
        do_reset();
        send_code(16'h1234);
        chk("t3_f1_pulse", fail_pulse, 1);
        @(posedge clk);
        #1;
        chk("t3_f1_fc", fail_count, 1);
        send_code(16'h6986);
        chk("t3_f2_pulse", fail_pulse, 1);
        @(posedge clk);
        #1;
        chk("t3_f2_fc", fail_count, 2);
        send_code(16'h0987);
        chk("t3_f3_pulse", fail_pulse, 1);
        lk[0] = 4'd6; lk[1] = 4'd9; lk[2] = 4'd8; lk[3] = 4'd7;
        lock_cyc  = 0;
        saw_entry = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk("t3_locked_first", locked,     1);
                chk("t3_locked_fc",    fail_count, 3);
                chk("t3_locked_estado", estado_led, 4);
            end
            if (locked) lock_cyc++;
            if (estado_led == 3'd1) saw_entry = 1'b1;
            enable_data = (i < 16) && ((i % 4) < 2);
            entrada_pw  = lk[(i / 4) % 4];
        end
        chk("t3_lock_cycles", lock_cyc,   20);
        chk("t3_no_entry",    saw_entry,  0);
        chk("t3_idle_estado", estado_led, 0);
        chk("t3_idle_fc",     fail_count, 0);
        send_code(16'h6987);
        chk("t3_fresh_pass", pass, 1);

        // Test 4a: timeout after two digits
        do_reset();
        send_digit(4'd6);
        send_digit(4'd9);
        fail_at = 0;
        pulses  = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (fail_pulse) begin
                pulses++;
                if (fail_at == 0) fail_at = n;
            end
        end
        chk("t4_timeout_seen",   (fail_at >= 48 && fail_at <= 52) ? 1 : 0, 1);
        chk("t4_timeout_pulses", pulses,     1);
        chk("t4_timeout_fc",     fail_count, 1);
        chk("t4_timeout_estado", estado_led, 0);

        // Test 4b: strobe lands on the timeout cycle; entry continues
        send_digit(4'd6);
        send_digit(4'd9);
        entrada_pw = 4'd8;
        saw_fail   = 1'b0;
        for (int k = 1; k <= 47; k++) begin
            @(posedge clk);
            #1;
            if (fail_pulse) saw_fail = 1'b1;
        end
        enable_data = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (fail_pulse) saw_fail = 1'b1;
        end
        chk("t4b_no_fail",      saw_fail,   0);
        chk("t4b_still_entry",  estado_led, 1);
        enable_data = 1'b0;
        send_digit(4'd7);
        chk("t4b_pass", pass,       1);
        chk("t4b_fc",   fail_count, 0);

        // Test 5: long hold with a one-cycle glitch -> two strobes
        do_reset();
        @(posedge clk);
        #1;
        enable_data = 1'b1;
        cnt = 0; p1 = -1; p2 = -1;
        for (int j = 1; j < 120; j++) begin
            @(posedge clk);
            #1;
            if (strobe_dbg) begin
                cnt++;
                if (cnt == 1) p1 = j;
                else if (cnt == 2) p2 = j;
            end
            enable_data = (j < 100) && (j != 50);
        end
        chk("t5_strobe_count", cnt, 2);
        chk("t5_strobe1_pos",  p1,  2);
        chk("t5_strobe2_pos",  p2,  53);

        // Test 6: asynchronous reset mid-entry
        do_reset();
        send_digit(4'd6);
        send_digit(4'd9);
        chk("t6_pre_estado", estado_led, 1);
        rst_a = 1'b0;
        #1;
        chk("t6_rst_pass",   pass,       0);
        chk("t6_rst_fail",   fail_pulse, 0);
        chk("t6_rst_locked", locked,     0);
        chk("t6_rst_estado", estado_led, 0);
        chk("t6_rst_fc",     fail_count, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        send_code(16'h6987);
        chk("t6_pass",        pass,       1);
        chk("t6_pass_estado", estado_led, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
